// File: rtl/riscv_pkg.sv
// Shared types for the load/writeback stage: load funct3 codes,
// FSM states, default widths and the load legality check.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } wb_state_e;

  // High for an unknown funct3 or an access not aligned to its size.
  function automatic logic ld_bad(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b1;
    unique case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = lo[0];
      F3_LW:         bad = |lo;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Bus bundle for load_writeback: load request, data-memory read,
// ALU writeback and register-file write port. slave = the stage.
interface load_writeback_if
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) ();

  logic            ld_valid;
  logic            ld_ready;
  logic [XLEN-1:0] ld_addr;
  logic [2:0]      ld_funct3;
  logic [RA_W-1:0] ld_rd;
  logic            ld_fault;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  logic            alu_wb_valid;
  logic            alu_ready;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;

  logic [RA_W-1:0] write_reg;
  logic [XLEN-1:0] write_data;
  logic            reg_write;

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, ld_rd,
    input  mem_ack, mem_rdata,
    input  alu_wb_valid, alu_rd, alu_data,
    output ld_ready, ld_fault,
    output mem_req, mem_addr,
    output alu_ready,
    output write_reg, write_data, reg_write
  );

  modport master (
    output ld_valid, ld_addr, ld_funct3, ld_rd,
    output mem_ack, mem_rdata,
    output alu_wb_valid, alu_rd, alu_data,
    input  ld_ready, ld_fault,
    input  mem_req, mem_addr,
    input  alu_ready,
    input  write_reg, write_data, reg_write
  );

endinterface

// File: rtl/load_writeback_extend.sv
// load_extend: picks the addressed byte/halfword of a little-endian
// word and sign/zero-extends it. In: funct3, addr[1:0], rdata. Out: data.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[7:0];
    unique case (off_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
      default: b = rdata_i[7:0];
    endcase
  end

  assign h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = '0;
    unique case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, b};
      F3_LH:   data_o = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, h};
      F3_LW:   data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Writeback stage: runs loads over a mem req/ack handshake and merges
// ALU results into the single register-file write port (clk, rst_n, bus).
module load_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  load_writeback_if.slave   bus
);

  wb_state_e       state_q, state_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            fault_q, fault_d;
  logic            wen_q, wen_d;
  logic [RA_W-1:0] wreg_q, wreg_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            pend_q, pend_d;
  logic [RA_W-1:0] prd_q, prd_d;
  logic [XLEN-1:0] pdata_q, pdata_d;

  logic            ld_acc;
  logic            ld_done;
  logic            alu_acc;
  logic [XLEN-1:0] ext;

  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3_i (f3_q),
    .off_i    (off_q),
    .rdata_i  (bus.mem_rdata),
    .data_o   (ext)
  );

  assign bus.ld_ready   = (state_q == S_IDLE);
  assign bus.alu_ready  = !pend_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.ld_fault   = fault_q;
  assign bus.reg_write  = wen_q;
  assign bus.write_reg  = wreg_q;
  assign bus.write_data = wdata_q;

  assign ld_acc  = bus.ld_valid && (state_q == S_IDLE);
  assign ld_done = (state_q == S_REQ) && bus.mem_ack;
  assign alu_acc = bus.alu_wb_valid && !pend_q;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    req_d   = req_q;
    maddr_d = maddr_q;
    fault_d = 1'b0;
    wen_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    prd_d   = prd_q;
    pdata_d = pdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (ld_acc) begin
          if (ld_bad(bus.ld_funct3, bus.ld_addr[1:0])) begin
            fault_d = 1'b1;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            maddr_d = {bus.ld_addr[XLEN-1:2], 2'b00};
            off_d   = bus.ld_addr[1:0];
            f3_d    = bus.ld_funct3;
            rd_d    = bus.ld_rd;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          state_d = S_WB;
          req_d   = 1'b0;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // One write per cycle: load result, then parked ALU entry,
    // then a freshly accepted ALU result.
    if (ld_done) begin
      wen_d   = (rd_q != '0);
      wreg_d  = rd_q;
      wdata_d = ext;
      if (alu_acc) begin
        pend_d  = 1'b1;
        prd_d   = bus.alu_rd;
        pdata_d = bus.alu_data;
      end
    end else if (pend_q) begin
      wen_d   = (prd_q != '0);
      wreg_d  = prd_q;
      wdata_d = pdata_q;
      pend_d  = 1'b0;
    end else if (alu_acc) begin
      wen_d   = (bus.alu_rd != '0);
      wreg_d  = bus.alu_rd;
      wdata_d = bus.alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      fault_q <= 1'b0;
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      pend_q  <= 1'b0;
      prd_q   <= '0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      fault_q <= fault_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      prd_q   <= prd_d;
      pdata_q <= pdata_d;
    end
  end

endmodule
